// File: rtl/cpu_step_sequencer.sv
// Multi-cycle step sequencer for the 8-bit, 4-register CPU: fetch latch, settle delay,
// single-pulse commit strobes, plus run/step/breakpoint/halt debug control.
module cpu_step_sequencer #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter logic [7:0]  HALT_INSTR  = 8'hFF,
  parameter int unsigned STEP_SYNC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  input  logic [7:0]  instruction,
  output logic [7:0]  ir,
  output logic        pc_en,
  output logic        commit_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StExec   = 3'd2,
    StCommit = 3'd3,
    StHalt   = 3'd4,
    StBreak  = 3'd5
  } state_e;

  localparam bit          ExecZero   = (EXEC_CYCLES == 0);
  localparam int unsigned CntInitInt = ExecZero ? 0 : EXEC_CYCLES - 1;
  localparam logic [3:0]  CntInit    = CntInitInt[3:0];

  state_e               state_q, state_d;
  logic [7:0]           ir_q, ir_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [15:0]          retired_q, retired_d;
  logic                 bp_skip_q, bp_skip_d;
  logic [STEP_SYNC-1:0] sync_q;
  logic                 edge_q;

  logic step_rise, go, launch_ok;

  assign step_rise = sync_q[STEP_SYNC-1] & ~edge_q;
  assign go        = run | step_rise;
  // bp_skip lets the breakpointed instruction launch once after leaving BREAK.
  assign launch_ok = !(bp_en && (pc == bp_addr) && !bp_skip_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
      bp_skip_q <= 1'b0;
      sync_q    <= '0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      bp_skip_q <= bp_skip_d;
      sync_q    <= {sync_q[STEP_SYNC-2:0], step};
      edge_q    <= sync_q[STEP_SYNC-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    bp_skip_d = bp_skip_q;
    case (state_q)
      StIdle: begin
        if (go) state_d = launch_ok ? StFetch : StBreak;
      end
      StFetch: begin
        ir_d = instruction;
        if (instruction == HALT_INSTR) begin
          state_d = StHalt;
        end else if (ExecZero) begin
          state_d = StCommit;
        end else begin
          state_d = StExec;
          cnt_d   = CntInit;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) state_d = StCommit;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StCommit: begin
        // Always return to IDLE so the new PC is compared against the breakpoint.
        retired_d = retired_q + 16'd1;
        bp_skip_d = 1'b0;
        state_d   = StIdle;
      end
      StBreak: begin
        if (step_rise) begin
          state_d   = StFetch;
          bp_skip_d = 1'b1;
        end else if (!run) begin
          state_d   = StIdle;
          bp_skip_d = 1'b1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Gated by reset so an aborted instruction never strobes a commit.
  assign pc_en     = (state_q == StCommit) & reset;
  assign commit_we = (state_q == StCommit) & reset;
  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign bp_hit    = (state_q == StBreak);
  assign ir        = ir_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer: instruction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cpu_step_sequencer;

  localparam int unsigned E      = 2;
  localparam int unsigned S      = 2;
  localparam logic [7:0]  HaltOp = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, step, bp_en;
  logic [7:0]  bp_addr, pc, instruction, ir;
  logic        pc_en, commit_we, halted, bp_hit;
  logic [2:0]  state;
  logic [15:0] retired;
  logic [7:0]  imem [256];

  logic        b_reset, b_run;
  logic [7:0]  b_pc, b_instr, b_ir;
  logic        b_pc_en, b_commit_we, b_halted, b_bp_hit;
  logic [2:0]  b_state;
  logic [15:0] b_retired;

  cpu_step_sequencer #(.EXEC_CYCLES(E), .HALT_INSTR(HaltOp), .STEP_SYNC(S)) dut_a (
    .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .instruction(instruction), .ir(ir), .pc_en(pc_en), .commit_we(commit_we),
    .state(state), .halted(halted), .bp_hit(bp_hit), .retired(retired)
  );

  cpu_step_sequencer #(.EXEC_CYCLES(0), .HALT_INSTR(HaltOp), .STEP_SYNC(S)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run), .step(1'b0), .bp_en(1'b0), .bp_addr(8'h00),
    .pc(b_pc), .instruction(b_instr), .ir(b_ir), .pc_en(b_pc_en), .commit_we(b_commit_we),
    .state(b_state), .halted(b_halted), .bp_hit(b_bp_hit), .retired(b_retired)
  );

  // Environment: PC register and instruction memory around each sequencer.
  assign instruction = imem[pc];
  assign b_instr     = b_pc ^ 8'h10;
  always @(posedge clk) begin
    if (!reset)     pc <= '0;
    else if (pc_en) pc <= pc + 8'd1;
    if (!b_reset)       b_pc <= '0;
    else if (b_pc_en)   b_pc <= b_pc + 8'd1;
  end

  // Reference model: an instruction is "in flight" for E+2 cycles after launch
  // (age 0 fetch, ages 1..E settle, age E+1 commit).
  localparam int MIdle = 0, MBusy = 1, MHalt = 2, MBrk = 3;
  int          m_mode  = MIdle;
  int unsigned m_age   = 0;
  logic [7:0]  m_ir    = '0;
  logic [15:0] m_ret   = '0;
  logic        m_skip  = 1'b0;
  logic [S:0]  m_hist  = '0;  // m_hist[j] = raw step sampled j edges ago
  logic        m_rise;
  logic        preload = 1'b0;

  always @(posedge clk) begin
    m_rise = m_hist[S-1] & ~m_hist[S];
    if (!reset) begin
      m_mode = MIdle; m_age = 0; m_ir = '0; m_ret = '0; m_skip = 1'b0; m_hist = '0;
    end else begin
      m_hist = {m_hist[S-1:0], step};
      if (preload) m_ret = 16'hFFFF;
      case (m_mode)
        MIdle: if (run || m_rise) begin
          if (bp_en && pc == bp_addr && !m_skip) m_mode = MBrk;
          else begin m_mode = MBusy; m_age = 0; end
        end
        MBusy: begin
          if (m_age == 0) begin
            m_ir = instruction;
            if (instruction == HaltOp) m_mode = MHalt;
            else                       m_age  = 1;
          end else if (m_age == E + 1) begin
            m_ret  = m_ret + 16'd1;
            m_skip = 1'b0;
            m_mode = MIdle;
          end else begin
            m_age = m_age + 1;
          end
        end
        MBrk: begin
          if (m_rise)    begin m_mode = MBusy; m_age = 0; m_skip = 1'b1; end
          else if (!run) begin m_mode = MIdle; m_skip = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;
  int   pulse_cnt, we_cnt;
  int   e_state;
  logic e_commit;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pc_en)     pulse_cnt++;
      if (commit_we) we_cnt++;
    end
  endtask

  initial begin
    int first, cnt, last, we_mis;
    reset = 1'b0; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = '0;
    b_reset = 1'b0; b_run = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'(i);

    fork
      forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
          e_commit = (m_mode == MBusy) && (m_age == E + 1) && reset;
          if      (m_mode == MIdle)   e_state = 0;
          else if (m_mode == MHalt)   e_state = 4;
          else if (m_mode == MBrk)    e_state = 5;
          else if (m_age == 0)        e_state = 1;
          else if (m_age == E + 1)    e_state = 3;
          else                        e_state = 2;
          check("m_state",     32'(state),     32'(e_state));
          check("m_ir",        32'(ir),        32'(m_ir));
          check("m_pc_en",     32'(pc_en),     32'(e_commit));
          check("m_commit_we", 32'(commit_we), 32'(e_commit));
          check("m_halted",    32'(halted),    32'(m_mode == MHalt));
          check("m_bp_hit",    32'(bp_hit),    32'(m_mode == MBrk));
          check("m_retired",   32'(retired),   32'(m_ret));
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_state",   32'(state),   32'd0);
    check("rst_ir",      32'(ir),      32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_pc_en",   32'(pc_en),   32'd0);
    check("b_rst_state", 32'(b_state), 32'd0);
    check("b_rst_ir",    32'(b_ir),    32'd0);
    check("b_rst_flags", 32'({b_halted, b_bp_hit}), 32'd0);
    chk_en = 1'b1;

    // Free run, EXEC_CYCLES=2: pulses at cycles 4, 9, 14, 19.
    run = 1'b1; reset = 1'b1;
    first = -1; cnt = 0; last = -1; we_mis = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pc_en) begin cnt++; last = n; if (first < 0) first = n; end
      if (pc_en != commit_we) we_mis++;
    end
    check("fr_first_pulse", 32'(first), 32'd4);
    check("fr_pulses",      32'(cnt),   32'd4);
    check("fr_last_pulse",  32'(last),  32'd19);
    check("fr_we_coincide", 32'(we_mis), 32'd0);
    check("fr_retired",     32'(retired), 32'd4);

    // Single step: three presses, plus a fourth press landing in EXEC.
    run = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulse_cnt = 0; we_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      step = 1'b1; run_cycles(3);
      step = 1'b0; run_cycles(17);
    end
    step = 1'b1; run_cycles(1);
    step = 1'b0; run_cycles(1);
    step = 1'b1; run_cycles(20);
    step = 1'b0; run_cycles(5);
    check("step_pulses",  32'(pulse_cnt), 32'd3);
    check("step_we",      32'(we_cnt),    32'd3);
    check("step_retired", 32'(retired),   32'd3);
    check("step_pc",      32'(pc),        32'd3);

    // Breakpoint at pc=3 with run held high.
    reset = 1'b0;
    @(negedge clk);
    bp_en = 1'b1; bp_addr = 8'h03; run = 1'b1; reset = 1'b1;
    for (int i = 0; i < 40 && !bp_hit; i++) run_cycles(1);
    check("bp_hit",     32'(bp_hit),  32'd1);
    check("bp_state",   32'(state),   32'd5);
    check("bp_retired", 32'(retired), 32'd3);
    pulse_cnt = 0;
    run_cycles(10);
    check("bp_stall_pulses", 32'(pulse_cnt), 32'd0);
    check("bp_still_hit",    32'(bp_hit),    32'd1);
    step = 1'b1; run_cycles(3);
    step = 1'b0; run_cycles(4);
    check("bp_step_pulses",  32'(pulse_cnt), 32'd1);
    check("bp_step_pc",      32'(pc),        32'd4);
    check("bp_step_retired", 32'(retired),   32'd4);
    check("bp_released",     32'(bp_hit),    32'd0);
    run_cycles(20);
    check("bp_resume_retired", 32'(retired), 32'd8);
    check("bp_resume_pc",      32'(pc),      32'd8);

    // Halt opcode at pc=5.
    reset = 1'b0;
    @(negedge clk);
    bp_en = 1'b0; imem[5] = HaltOp; reset = 1'b1; run = 1'b1;
    for (int i = 0; i < 50 && !halted; i++) run_cycles(1);
    check("halt_flag",    32'(halted),  32'd1);
    check("halt_ir",      32'(ir),      32'hFF);
    check("halt_state",   32'(state),   32'd4);
    check("halt_retired", 32'(retired), 32'd5);
    pulse_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step = 1'b1; run_cycles(4);
      step = 1'b0; run_cycles(4);
    end
    check("halt_no_pc_en", 32'(pulse_cnt), 32'd0);
    check("halt_no_we",    32'(we_cnt),    32'd0);
    check("halt_stays",    32'(halted),    32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_ir",    32'(ir),    32'd0);
    check("halt_rst_flags", 32'({halted, bp_hit, pc_en, commit_we}), 32'd0);
    check("halt_rst_ret",   32'(retired), 32'd0);
    run = 1'b0; reset = 1'b1; imem[5] = 8'h05;

    // Retired counter wrap from a preloaded 16'hFFFF.
    @(negedge clk);
    chk_en = 1'b0;
    force dut_a.retired_q = 16'hFFFF;
    preload = 1'b1;
    @(negedge clk);
    release dut_a.retired_q;
    preload = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("wrap_preload", 32'(retired), 32'hFFFF);
    pulse_cnt = 0;
    step = 1'b1; run_cycles(3);
    step = 1'b0; run_cycles(5);
    check("wrap_pulses",  32'(pulse_cnt), 32'd1);
    check("wrap_retired", 32'(retired),   32'd0);

    // Reset during EXEC, then during COMMIT.
    run = 1'b1;
    for (int i = 0; i < 20 && state != 3'd2; i++) run_cycles(1);
    check("rexec_in_exec", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    check("rexec_pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    check("rexec_state", 32'(state), 32'd0);
    check("rexec_ir",    32'(ir),    32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20 && state != 3'd3; i++) run_cycles(1);
    check("rcommit_in_commit", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    check("rcommit_strobes", 32'({pc_en, commit_we}), 32'd0);
    @(negedge clk);
    check("rcommit_retired", 32'(retired), 32'd0);
    run = 1'b0; reset = 1'b1;

    // Free run with EXEC_CYCLES=0: pulses at cycles 2, 5, ..., 20.
    b_run = 1'b1; b_reset = 1'b1;
    first = -1; cnt = 0; last = -1; we_mis = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b_pc_en) begin cnt++; last = n; if (first < 0) first = n; end
      if (b_pc_en != b_commit_we) we_mis++;
    end
    check("e0_first_pulse", 32'(first),     32'd2);
    check("e0_pulses",      32'(cnt),       32'd7);
    check("e0_last_pulse",  32'(last),      32'd20);
    check("e0_we_coincide", 32'(we_mis),    32'd0);
    check("e0_retired",     32'(b_retired), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_sequencer.md
Name: cpu_step_sequencer

Overview:
- Multi-cycle sequencer for the 8-bit, 4-register CPU datapath.
- Latches each fetched instruction and allows EXEC_CYCLES of settle time for the ALU and data memory.
- Gates the commit strobes for the PC, register-file write and data-memory write to one pulse per instruction.
- Supports free-run, single-step from a board button, a PC breakpoint and a halt instruction, for board-level debug via the 7-segment display.

Parameters:
- EXEC_CYCLES, 2, settle cycles between FETCH and COMMIT (0..15; 0 means FETCH goes directly to COMMIT).
- HALT_INSTR, 8'hFF, opcode pattern that halts the core; 8'hFF is "beq $3,$3,-1", a self-loop.
- STEP_SYNC, 2, synchronizer flop count on the step button (minimum 2).

Ports:
- clk  in  1  system clock (divided clock).
- reset  in  1  synchronous, active-low reset.
- run  in  1  level input; 1 = free-run, 0 = stepping/idle.
- step  in  1  raw button input; asynchronous to clk.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  8  breakpoint PC value.
- pc  in  8  current PC register output.
- instruction  in  8  instruction-memory data at pc.
- ir  out  8  latched instruction that drives the control decode.
- pc_en  out  1  PC load enable; one-cycle pulse.
- commit_we  out  1  qualifier ANDed with RegWrite/MemWrite; one-cycle pulse.
- state  out  3  current FSM state code.
- halted  out  1  high in HALT.
- bp_hit  out  1  high in BREAK.
- retired  out  16  count of committed instructions.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; ir=0, pc_en=0, commit_we=0, halted=0, bp_hit=0, retired=0.
  - Synchronizer flops, edge register, exec counter and bp_skip all cleared.
  - Reset asserted in any state aborts the instruction in flight; no pc_en/commit_we pulse that cycle.
- Step input:
  - step passes through STEP_SYNC flops.
  - step_rise = sync & ~sync_d; one cycle wide.
  - Rise-to-pulse latency is STEP_SYNC+1 cycles.
  - step_rise is consumed only in IDLE or BREAK; elsewhere it is dropped, not queued.
- go = run | step_rise.
- launch_ok = !(bp_en && pc==bp_addr && !bp_skip).
- State codes: IDLE=0, FETCH=1, EXEC=2, COMMIT=3, HALT=4, BREAK=5.
- Transitions:
  - IDLE: if go and launch_ok -> FETCH; if go and !launch_ok -> BREAK; else stay in IDLE.
  - FETCH: ir<=instruction.
    - If instruction==HALT_INSTR -> HALT; ir still loads, nothing commits.
    - Else if EXEC_CYCLES==0 -> COMMIT.
    - Else -> EXEC with cnt=EXEC_CYCLES-1.
  - EXEC: if cnt==0 -> COMMIT, else cnt<=cnt-1.
  - COMMIT: pc_en=1 and commit_we=1 for exactly this cycle; retired<=retired+1, wrapping 16'hFFFF->0; bp_skip<=0; -> IDLE unconditionally, so the PC settles before the next breakpoint compare.
  - BREAK: bp_hit=1.
    - step_rise -> FETCH with bp_skip<=1, which executes the breakpointed instruction once.
    - Else if run==0 -> IDLE with bp_skip<=1.
    - Else stay in BREAK.
    - step_rise has priority over run==0.
  - HALT: halted=1; absorbing state; only reset exits.
- pc_en and commit_we are combinational decodes of state==COMMIT; they are never high in any other state.
- Free-run throughput: one instruction per EXEC_CYCLES+3 cycles (IDLE, FETCH, EXEC×N, COMMIT); 5 cycles at the default.
- run dropping mid-instruction: the current instruction completes through COMMIT, then the FSM stays in IDLE.
- ir holds its value outside FETCH; the decode stays stable through EXEC and COMMIT.
- Breakpoint match is evaluated on pc in IDLE only; changing bp_addr mid-instruction has no effect until the next IDLE.

Test Plan:
- Reset, run=1, EXEC_CYCLES=2, program of non-halt instructions:
  - pc_en pulses every 5 cycles, first pulse at cycle 4 after reset release.
  - retired reads 4 after 20 cycles.
  - commit_we is coincident with every pc_en pulse.
- run=0, three step presses spaced 20 cycles apart:
  - Exactly three pc_en pulses; retired=3.
  - A fourth press issued during EXEC produces no extra pulse.
- bp_en=1, bp_addr=8'h03, run=1:
  - BREAK entered when pc==3; bp_hit=1; retired=3; no pc_en while stalled.
  - One step press: exactly one instruction commits and pc advances past 3.
  - The core then free-runs again because run is still 1.
- instruction=8'hFF fetched at pc=5:
  - HALT with halted=1, ir=8'hFF, no commit_we.
  - Step presses and run toggling are ignored.
  - reset=0 for one cycle returns to IDLE with all outputs 0.
- retired preloaded to 16'hFFFF via force, one commit: wraps to 16'h0000.
- reset=0 asserted during EXEC: next state IDLE, no pc_en pulse, ir=0.
- Repeat the first scenario with EXEC_CYCLES=0: 3-cycle period.
